// File: rtl/lifo_arbiter.sv
// lifo_arbiter: round-robin sequencer sharing one LIFO stack among NREQ requesters,
// screening push-on-full and pop-on-empty into error responses.
module lifo_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       i_req_push,
    input  logic [NREQ-1:0]       i_req_pop,
    input  logic [NREQ*WIDTH-1:0] i_req_din,
    output logic [NREQ-1:0]       o_gnt,
    output logic [NREQ-1:0]       o_rsp_valid,
    output logic [NREQ-1:0]       o_rsp_err,
    output logic [WIDTH-1:0]      o_rsp_data,
    output logic                  o_stk_push,
    output logic                  o_stk_pop,
    output logic [WIDTH-1:0]      o_stk_din,
    input  logic [WIDTH-1:0]      i_stk_dout,
    input  logic                  i_stk_empty,
    input  logic                  i_stk_full
);
    localparam int IW = $clog2(NREQ);
    localparam logic [IW:0] NR = (IW+1)'(NREQ);
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_winner;
    logic            r_op;
    logic [NREQ-1:0] w_active;
    logic [NREQ-1:0] w_sel;
    logic [IW:0]     w_idx;
    logic [IW-1:0]   w_pick;
    logic            w_found;
    logic            w_issue;
    logic            w_resp;
    logic            w_push_ok;
    logic            w_pop_ok;
    logic            w_err;

    assign w_active = i_req_push | i_req_pop;

    // first active requester scanning upward from r_ptr, wrapping at NREQ
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (IW+1)'(k);
            w_idx = (w_idx >= NR) ? w_idx - NR : w_idx;
            if (!w_found && w_active[w_idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_winner <= '0;
            r_op     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_winner <= w_pick;
                    r_op     <= i_req_pop[w_pick];
                    r_ptr    <= (w_pick == LAST) ? '0 : w_pick + 1'b1;
                    r_state  <= ISSUE;
                end
                ISSUE:   r_state <= w_pop_ok ? RESP : IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // gating with rstn drops an in-flight grant/response on the reset cycle
    assign w_issue   = rstn && (r_state == ISSUE);
    assign w_resp    = rstn && (r_state == RESP);
    assign w_push_ok = w_issue && !r_op && !i_stk_full;
    assign w_pop_ok  = w_issue && r_op && !i_stk_empty;
    assign w_err     = w_issue && (r_op ? i_stk_empty : i_stk_full);
    assign w_sel     = NREQ'(1) << r_winner;

    assign o_gnt       = w_issue ? w_sel : '0;
    assign o_rsp_err   = w_err ? w_sel : '0;
    assign o_rsp_valid = w_resp ? w_sel : '0;
    assign o_rsp_data  = w_resp ? i_stk_dout : '0;
    assign o_stk_push  = w_push_ok;
    assign o_stk_pop   = w_pop_ok;
    assign o_stk_din   = w_push_ok ? i_req_din[r_winner*WIDTH +: WIDTH] : '0;
endmodule
